// File: rtl/seq_div_pkg.sv
// seq_div_pkg: FSM state encoding and default operand width for seq_div
package seq_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/seq_div_step.sv
// seq_div_step: one restoring shift-subtract step, MSB of the dividend shifted in first
module seq_div_step
    import seq_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;

    // shift next dividend bit into the remainder, trial subtract, restore on borrow
    always_comb begin
        shifted = {rem_in, quo_in[WIDTH-1]};
        diff    = shifted - {2'b00, divisor};
        rem_out = diff[WIDTH+1] ? shifted[WIDTH:0] : diff[WIDTH:0];
        quo_out = {quo_in[WIDTH-2:0], ~diff[WIDTH+1]};
    end

endmodule

// File: rtl/seq_div.sv
// seq_div: sequential restoring unsigned divider; define SEQ_DIV_DZ_EN for single-cycle divide-by-zero
module seq_div
    import seq_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             C,
    input  logic             RN,
    input  logic             START,
    input  logic [WIDTH-1:0] DIVIDEND,
    input  logic [WIDTH-1:0] DIVISOR,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] QUO,
    output logic [WIDTH-1:0] REM,
    output logic             DZ
);

    localparam int CW = $clog2(WIDTH);

    state_t           state, nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   rem_w, rem_nx;
    logic [WIDTH-1:0] quo_w, quo_nx;
    logic [WIDTH-1:0] dvsr;
    logic             accept, last, fast_dz;

`ifdef SEQ_DIV_DZ_EN
    logic dz_r;
    assign fast_dz = DIVISOR == '0;
    assign DZ      = dz_r;
`else
    assign fast_dz = 1'b0;
    assign DZ      = 1'b0;
`endif

    assign BUSY = state == RUN;
    assign DONE = state == FIN;

    seq_div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_w),
        .quo_in  (quo_w),
        .divisor (dvsr),
        .rem_out (rem_nx),
        .quo_out (quo_nx)
    );

    // state register
    always_ff @(posedge C or negedge RN) begin
        if (!RN) state <= IDLE;
        else     state <= nxt;
    end

    // next state: START is honoured only outside RUN; FIN always lasts one cycle
    always_comb begin
        nxt    = state;
        accept = START && state != RUN;
        last   = cnt == CW'(WIDTH - 1);
        if (accept)             nxt = fast_dz ? FIN : RUN;
        else if (state == RUN)  nxt = last ? FIN : RUN;
        else if (state == FIN)  nxt = IDLE;
    end

    // datapath: latch operands on accept, iterate in RUN, publish results only on completion
    always_ff @(posedge C or negedge RN) begin
        if (!RN) begin
            cnt   <= '0;
            rem_w <= '0;
            quo_w <= '0;
            dvsr  <= '0;
            QUO   <= '0;
            REM   <= '0;
`ifdef SEQ_DIV_DZ_EN
            dz_r  <= 1'b0;
`endif
        end else if (accept) begin
            cnt   <= '0;
            rem_w <= '0;
            quo_w <= DIVIDEND;
            dvsr  <= DIVISOR;
`ifdef SEQ_DIV_DZ_EN
            if (fast_dz) begin
                QUO  <= '1;
                REM  <= DIVIDEND;
                dz_r <= 1'b1;
            end
`endif
        end else if (state == RUN) begin
            cnt   <= cnt + 1'b1;
            rem_w <= rem_nx;
            quo_w <= quo_nx;
            if (last) begin
                QUO  <= quo_nx;
                REM  <= rem_nx[WIDTH-1:0];
`ifdef SEQ_DIV_DZ_EN
                dz_r <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_seq_div.sv
// tb_seq_div: randomized self-checking bench for seq_div against an arithmetic reference
module tb_seq_div;

    localparam int W = 8;

    logic         C = 1'b0;
    logic         RN = 1'b0;
    logic         START = 1'b0;
    logic [W-1:0] DIVIDEND = '0;
    logic [W-1:0] DIVISOR = '0;
    logic         BUSY, DONE, DZ;
    logic [W-1:0] QUO, REM;

    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0] prev_q = '0;
    logic [W-1:0] prev_r = '0;

    seq_div #(.WIDTH(W)) dut (
        .C        (C),
        .RN       (RN),
        .START    (START),
        .DIVIDEND (DIVIDEND),
        .DIVISOR  (DIVISOR),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .QUO      (QUO),
        .REM      (REM),
        .DZ       (DZ)
    );

    always #5 C = ~C;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_q(input logic [W-1:0] a, input logic [W-1:0] b);
        return b == 0 ? {W{1'b1}} : W'(int'(a) / int'(b));
    endfunction

    function automatic logic [W-1:0] ref_r(input logic [W-1:0] a, input logic [W-1:0] b);
        return b == 0 ? a : W'(int'(a) % int'(b));
    endfunction

    function automatic bit fast_zero(input logic [W-1:0] b);
`ifdef SEQ_DIV_DZ_EN
        return b == 0;
`else
        return 1'b0;
`endif
    endfunction

    // one division; poke > 0 pulses START with 9/3 at that cycle of RUN
    task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, input string tag, input int poke);
        int nb = 0;
        int cyc = 0;
        @(negedge C);
        START = 1'b1; DIVIDEND = a; DIVISOR = b;
        @(negedge C);
        cyc = 1;
        START = 1'b0;
        while (!DONE && cyc < 40) begin
            if (BUSY) nb++;
            if (cyc == 2 && BUSY) begin
                check({tag, "_hold_q"}, QUO, prev_q);
                check({tag, "_hold_r"}, REM, prev_r);
            end
            if (cyc == poke) begin
                START = 1'b1; DIVIDEND = 8'd9; DIVISOR = 8'd3;
            end
            @(negedge C);
            START = 1'b0;
            cyc++;
        end
        check({tag, "_done"}, DONE, 1);
        check({tag, "_busy_cycles"}, nb, fast_zero(b) ? 0 : W);
        check({tag, "_quo"}, QUO, ref_q(a, b));
        check({tag, "_rem"}, REM, ref_r(a, b));
        check({tag, "_dz"}, DZ, fast_zero(b));
        prev_q = ref_q(a, b);
        prev_r = ref_r(a, b);
        @(negedge C);
        check({tag, "_done_pulse"}, DONE, 0);
        check({tag, "_busy_after"}, BUSY, 0);
        check({tag, "_quo_held"}, QUO, prev_q);
    endtask

    initial begin
        int t1;
        int t2;
        int seen;
        logic [W-1:0] a;
        logic [W-1:0] b;
        #2;
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);
        check("rst_quo", QUO, 0);
        check("rst_rem", REM, 0);
        check("rst_dz", DZ, 0);
        @(negedge C);
        RN = 1'b1;

        do_div(8'd100, 8'd7, "d100_7", 0);
        do_div(8'd255, 8'd1, "d255_1", 0);
        do_div(8'd3, 8'd200, "d3_200", 0);
        do_div(8'd5, 8'd0, "d5_0", 0);
        do_div(8'd100, 8'd7, "ignore", 4);

        @(negedge C);
        START = 1'b1; DIVIDEND = 8'd100; DIVISOR = 8'd7;
        @(negedge C);
        START = 1'b0;
        repeat (2) @(negedge C);
        RN = 1'b0;
        #1;
        check("abort_busy", BUSY, 0);
        check("abort_done", DONE, 0);
        check("abort_quo", QUO, 0);
        check("abort_rem", REM, 0);
        check("abort_dz", DZ, 0);
        @(negedge C);
        RN = 1'b1;
        prev_q = '0;
        prev_r = '0;
        seen = 0;
        repeat (12) begin
            @(negedge C);
            if (DONE) seen++;
        end
        check("abort_no_done", seen, 0);
        do_div(8'd50, 8'd5, "d50_5", 0);

        @(negedge C);
        START = 1'b1; DIVIDEND = 8'd100; DIVISOR = 8'd7;
        t1 = -1; t2 = -1;
        for (int i = 0; i < 40 && t2 < 0; i++) begin
            @(negedge C);
            if (DONE) begin
                check("b2b_quo", QUO, 14);
                check("b2b_rem", REM, 2);
                if (t1 < 0) t1 = i;
                else t2 = i;
            end
        end
        START = 1'b0;
        check("b2b_spacing", t2 - t1, 9);
        @(negedge C);
        check("b2b_done_end", DONE, 0);
        prev_q = 8'd14;
        prev_r = 8'd2;

        for (int i = 0; i < 40; i++) begin
            a = W'($urandom);
            b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            do_div(a, b, "rand", ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W - 1)) : 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_div.md
SEQ_DIV -- requirements
Module: seq_div

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, operand and result width in bits (legal range 2..32).
REQ-002 The block SHALL have port C, input, 1 bit: the clock; all state updates on its rising edge.
REQ-003 The block SHALL have port RN, input, 1 bit: the reset, asynchronous and active-low.
REQ-004 The block SHALL have port START, input, 1 bit: request a division.
REQ-005 The block SHALL have port DIVIDEND, input, WIDTH bits: unsigned numerator, sampled when START is accepted.
REQ-006 The block SHALL have port DIVISOR, input, WIDTH bits: unsigned denominator, sampled when START is accepted.
REQ-007 The block SHALL have port BUSY, output, 1 bit: high while a division is in progress.
REQ-008 The block SHALL have port DONE, output, 1 bit: one-cycle pulse marking valid results.
REQ-009 The block SHALL have port QUO, output, WIDTH bits: quotient.
REQ-010 The block SHALL have port REM, output, WIDTH bits: remainder.
REQ-011 The block SHALL have port DZ, output, 1 bit: divide-by-zero flag, valid with DONE (see REQ-027).

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and FIN.
REQ-013 START SHALL be accepted only at a rising edge of C when the FSM is in IDLE or FIN; at acceptance, the block latches DIVIDEND and DIVISOR, clears the iteration counter and enters RUN.
REQ-014 START while in RUN SHALL be ignored; the operation in flight and the latched operands are unaffected.
REQ-015 RUN SHALL perform one restoring shift-subtract step per cycle, MSB first, for exactly WIDTH cycles, using a partial remainder of WIDTH+1 bits.
REQ-016 BUSY SHALL be 1 in exactly the WIDTH cycles following the accepting edge and 0 otherwise.
REQ-017 At the edge completing step WIDTH, the block SHALL register QUO and REM, enter FIN and assert DONE for exactly one cycle.
REQ-018 QUO, REM and DZ SHALL hold their values until the next accepted START completes; they SHALL NOT change while the next operation is in RUN.
REQ-019 From FIN, the block SHALL return to IDLE at the next edge unless START is high, in which case it SHALL enter RUN (back-to-back operation, no idle cycle).
REQ-020 Results SHALL satisfy DIVIDEND = QUO*DIVISOR + REM and REM < DIVISOR for every nonzero DIVISOR.
REQ-021 With DIVISOR = 0, the result SHALL be QUO = all ones and REM = DIVIDEND.

Reset
REQ-022 When RN is low, the block SHALL enter IDLE asynchronously and drive BUSY, DONE, DZ, QUO, REM and the counter to 0.
REQ-023 Reset asserted during RUN SHALL abort the operation; no DONE pulse SHALL follow release.
REQ-024 After RN deasserts, the first rising edge of C with START high SHALL be accepted normally.

Configuration
REQ-025 The macro SEQ_DIV_DZ_EN SHALL control fast divide-by-zero handling.
REQ-026 When SEQ_DIV_DZ_EN is defined, an accepted START with DIVISOR = 0 SHALL skip RUN, enter FIN at the next edge with DONE = 1, DZ = 1, and the REQ-021 values, and keep BUSY at 0.
REQ-027 When SEQ_DIV_DZ_EN is undefined, DZ SHALL be tied to 0, and DIVISOR = 0 SHALL take the normal WIDTH-cycle path, producing the REQ-021 values naturally.

Structure
REQ-028 The package seq_div_pkg SHALL hold the state typedef (IDLE/RUN/FIN encoding) and the default-WIDTH constant.
REQ-029 The single restoring step (shift, trial subtract, restore select) SHALL be the combinational sub-module seq_div_step, instantiated once in seq_div.

Verification
REQ-030 Bench SHALL check: WIDTH=8, 100/7 -> BUSY high for 8 cycles, then DONE pulse, QUO=14, REM=2.
REQ-031 Bench SHALL check: 255/1 -> QUO=255, REM=0; and 3/200 -> QUO=0, REM=3.
REQ-032 Bench SHALL check, with SEQ_DIV_DZ_EN defined: 5/0 -> DONE one cycle after accept, BUSY stays 0, DZ=1, QUO=255, REM=5. With the macro undefined: DONE after 8 BUSY cycles, DZ=0, same QUO and REM.
REQ-033 Bench SHALL check: 100/7 in flight, then START pulsed with 9/3 at cycle 4 -> ignored; the result is still 14 rem 2.
REQ-034 Bench SHALL check: RN pulsed low at cycle 3 of RUN -> all outputs 0 and no DONE pulse; then 50/5 -> QUO=10, REM=0.
REQ-035 Bench SHALL check: START held high through FIN -> back-to-back results with DONE pulses exactly 9 cycles apart.
